// File: rtl/rz_pkg.sv
// rz_pkg: shared RZ line timing constants (100 MHz) and receiver state type for the RZ encoder/decoder pair.
package rz_pkg;
  localparam int T_BIT_CYC = 125;
  localparam int T0H_CYC   = 31;
  localparam int T1H_CYC   = 91;
  localparam int RESET_CYC = 5000;
  localparam int CNT_W     = 13;
  typedef enum logic {HUNT, RUN} rx_state_t;
endpackage

// File: rtl/rz_pulse_meter.sv
// rz_pulse_meter: synchronizes the raw RZ line and measures high/low run lengths.
//   clk, rst_n      : clock, async active-low reset
//   in              : raw line (asynchronous)
//   rise, fall      : single-cycle edges of the synchronized line
//   hi_cnt          : high run length, valid on fall, saturates at HI_SAT
//   lo_at_reset     : high in the cycle the low run length reaches LO_SAT
module rz_pulse_meter import rz_pkg::*; #(
  parameter int HI_SAT = 171,
  parameter int LO_SAT = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic             rise,
  output logic             fall,
  output logic             lo_at_reset,
  output logic [CNT_W-1:0] hi_cnt
);
  logic sync1, line_s, line_d;
  logic [CNT_W-1:0] lo_cnt, hi_nxt, lo_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1  <= 1'b0;
      line_s <= 1'b0;
      line_d <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      sync1  <= in;
      line_s <= sync1;
      line_d <= line_s;
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
    end
  assign rise = line_s & ~line_d;
  assign fall = ~line_s & line_d;
  // The edge cycle itself is the first cycle of the new level, so the count restarts at 1
  // and reads exactly N after an N-cycle run.
  assign hi_nxt = rise ? CNT_W'(1) : (line_s && hi_cnt < CNT_W'(HI_SAT)) ? hi_cnt + 1'b1 : hi_cnt;
  assign lo_nxt = fall ? CNT_W'(1) : (!line_s && lo_cnt < CNT_W'(LO_SAT)) ? lo_cnt + 1'b1 : lo_cnt;
  // Fires once per low run; a saturated counter holding at LO_SAT does not retrigger.
  assign lo_at_reset = lo_nxt == CNT_W'(LO_SAT) && lo_cnt != CNT_W'(LO_SAT);
endmodule

// File: rtl/rz_decoder.sv
// rz_decoder: WS2812-style RZ line decoder assembling MSB-first words onto a valid/ready stream.
//   clk, rst_n          : clock (100 MHz), async active-low reset
//   in                  : raw RZ line (asynchronous)
//   m_data/m_valid/m_ready : output word stream, single holding register
//   frame_end           : pulse when a reset low is seen while running
//   err                 : pulse on a malformed pulse or a partial word at frame end
//   overrun             : pulse when a completed word is dropped
//   err_cnt             : saturating err+overrun count, only with RZ_DECODER_ERR_CNT_EN
module rz_decoder #(
  parameter int T0H_MIN   = 15,
  parameter int T0H_MAX   = 50,
  parameter int T1H_MIN   = 60,
  parameter int T1H_MAX   = 170,
  parameter int RESET_CYC = 5000,
  parameter int WORD_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  output logic [WORD_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 frame_end,
  output logic                 err,
  output logic                 overrun
`ifdef RZ_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);
  import rz_pkg::*;
  localparam int BW = $clog2(WORD_BITS);
  rx_state_t state, state_nxt;
  logic fall, lo_at_reset, unused_rise;
  logic [CNT_W-1:0] hi_cnt;
  logic [WORD_BITS-1:0] shreg, word_in;
  logic [BW-1:0] bit_cnt;
  logic is0, is1, shift, bad, frame_evt, word_done, part_err;
  rz_pulse_meter #(.HI_SAT(T1H_MAX + 1), .LO_SAT(RESET_CYC)) u_meter (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .rise(unused_rise),
    .fall(fall),
    .lo_at_reset(lo_at_reset),
    .hi_cnt(hi_cnt)
  );
  assign is0 = hi_cnt >= CNT_W'(T0H_MIN) && hi_cnt <= CNT_W'(T0H_MAX);
  assign is1 = hi_cnt >= CNT_W'(T1H_MIN) && hi_cnt <= CNT_W'(T1H_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    bad       = 1'b0;
    frame_evt = 1'b0;
    if (state == HUNT) state_nxt = lo_at_reset ? RUN : HUNT;
    else if (fall) begin
      shift     = is0 | is1;
      bad       = ~(is0 | is1);
      state_nxt = bad ? HUNT : RUN;
    end else frame_evt = lo_at_reset;
  end
  assign word_done = shift && bit_cnt == BW'(WORD_BITS - 1);
  assign part_err  = frame_evt && bit_cnt != '0;
  assign word_in   = {shreg[WORD_BITS-2:0], is1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_end <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_end <= frame_evt;
      err       <= bad | part_err;
      overrun   <= word_done & m_valid & ~m_ready;
      if (bad || frame_evt) bit_cnt <= '0;
      else if (shift) bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      if (shift) shreg <= word_in;
      if (word_done && (!m_valid || m_ready)) begin
        m_data  <= word_in;
        m_valid <= 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
    end
`ifdef RZ_DECODER_ERR_CNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + 17'(err) + 17'(overrun);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
endmodule

// File: tb/tb_rz_decoder.sv
// tb_rz_decoder: table-driven and hand-sequenced checks of rz_decoder with a word scoreboard.
module tb_rz_decoder;
  import rz_pkg::*;
  logic clk = 0, rst_n = 0, in = 0, m_ready = 0;
  logic [23:0] m_data;
  logic m_valid, frame_end, err, overrun;
`ifdef RZ_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  always #5 clk = ~clk;
  rz_decoder dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_end(frame_end),
    .err(err),
    .overrun(overrun)
`ifdef RZ_DECODER_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );
  int checks = 0, errors = 0;
  int err_n = 0, fe_n = 0, ov_n = 0, both_n = 0, words_n = 0;
  logic [23:0] q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      err_n  += int'(err);
      fe_n   += int'(frame_end);
      ov_n   += int'(overrun);
      both_n += int'(err & frame_end);
      if (m_valid && m_ready) begin
        words_n++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got unexpected %0h expected none", m_data);
        end else chk("word", {8'h0, m_data}, {8'h0, q.pop_front()});
      end
    end
  end
  task automatic idle(input int n);
    in = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input int h0, input int h1, input bit rdy);
    int w, lo;
    w  = b ? h1 : h0;
    lo = (T_BIT_CYC - w < 30) ? 30 : T_BIT_CYC - w;
    in = 1;
    repeat (w) @(negedge clk);
    in = 0;
    if (rdy) begin
      repeat (2) @(negedge clk);
      m_ready = 1;
      @(negedge clk);
      m_ready = 0;
      repeat (lo - 3) @(negedge clk);
    end else repeat (lo) @(negedge clk);
  endtask
  task automatic send_word(input logic [23:0] w, input int n, input int h0, input int h1, input bit rdy_last);
    for (int i = 0; i < n; i++) send_bit(w[23-i], h0, h1, rdy_last && i == n - 1);
  endtask
  task automatic bad_pulse(input int w);
    in = 1;
    repeat (w) @(negedge clk);
    in = 0;
    repeat (60) @(negedge clk);
  endtask
  typedef struct {
    logic [23:0] word;
    int nbits, h0, h1, bad_w, pre;
    bit tail;
    int ex_words, ex_err, ex_fe, ex_both;
  } vec_t;
  vec_t tv[7];
  int s_w, s_e, s_f, s_b, s_o;
  task automatic snap();
    s_w = words_n; s_e = err_n; s_f = fe_n; s_b = both_n; s_o = ov_n;
  endtask
  initial begin
    tv[0] = '{24'hA5C33C, 24, 31, 91, 0, 0, 1'b1, 1, 0, 1, 0};
    tv[1] = '{24'h123456, 10, 31, 91, 0, 0, 1'b1, 0, 1, 1, 1};
    tv[2] = '{24'h3C5A96, 24, 31, 91, 55, 5, 1'b0, 1, 1, 0, 0};
    tv[3] = '{24'h000000, 0, 31, 91, 8, 0, 1'b0, 0, 1, 0, 0};
    tv[4] = '{24'h000000, 0, 31, 91, 200, 12, 1'b0, 0, 1, 0, 0};
    tv[5] = '{24'h6DB2E1, 24, 16, 169, 0, 0, 1'b0, 1, 0, 0, 0};
    tv[6] = '{24'h924D1E, 24, 49, 61, 0, 0, 1'b0, 1, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst m_data", {8'h0, m_data}, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst frame_end", frame_end, 0);
    chk("rst err", err, 0);
    chk("rst overrun", overrun, 0);
`ifdef RZ_DECODER_ERR_CNT_EN
    chk("rst err_cnt", err_cnt, 0);
`endif
    rst_n = 1;
    idle(5010);
    chk("hunt m_valid", m_valid, 0);
    chk("hunt frame_end cnt", fe_n, 0);
    m_ready = 1;
    for (int i = 0; i < 7; i++) begin
      snap();
      if (tv[i].bad_w != 0) begin
        send_word(tv[i].word, tv[i].pre, 31, 91, 0);
        bad_pulse(tv[i].bad_w);
        send_word(24'hFFFFFF, 3, 31, 91, 0);
        idle(5010);
      end
      if (tv[i].nbits == 24) q.push_back(tv[i].word);
      send_word(tv[i].word, tv[i].nbits, tv[i].h0, tv[i].h1, 0);
      if (tv[i].tail) idle(5010);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d words", i), words_n - s_w, tv[i].ex_words);
      chk($sformatf("v%0d err", i), err_n - s_e, tv[i].ex_err);
      chk($sformatf("v%0d frame_end", i), fe_n - s_f, tv[i].ex_fe);
      chk($sformatf("v%0d err&fe", i), both_n - s_b, tv[i].ex_both);
      chk($sformatf("v%0d overrun", i), ov_n - s_o, 0);
    end
    m_ready = 0;
    snap();
    q.push_back(24'h111111);
    send_word(24'h111111, 24, 31, 91, 0);
    send_word(24'hEEEEEE, 24, 31, 91, 0);
    repeat (5) @(negedge clk);
    chk("ovr overrun", ov_n - s_o, 1);
    chk("ovr m_valid", m_valid, 1);
    chk("ovr m_data", {8'h0, m_data}, 32'h111111);
    m_ready = 1;
    repeat (3) @(negedge clk);
    m_ready = 0;
    chk("ovr drain m_valid", m_valid, 0);
    chk("ovr words", words_n - s_w, 1);
    snap();
    q.push_back(24'h5A5A5A);
    q.push_back(24'hC3C3C3);
    send_word(24'h5A5A5A, 24, 31, 91, 0);
    send_word(24'hC3C3C3, 24, 31, 91, 1);
    repeat (2) @(negedge clk);
    chk("same m_valid", m_valid, 1);
    chk("same m_data", {8'h0, m_data}, 32'hC3C3C3);
    chk("same words", words_n - s_w, 1);
    chk("same overrun", ov_n - s_o, 0);
    m_ready = 1;
    repeat (3) @(negedge clk);
    chk("same drained", q.size(), 0);
    chk("same m_valid end", m_valid, 0);
    m_ready = 0;
    q.push_back(24'h0F0F0F);
    send_word(24'h0F0F0F, 24, 31, 91, 0);
    send_word(24'hF0F0F0, 10, 31, 91, 0);
    rst_n = 0;
    #1;
    chk("arst m_valid", m_valid, 0);
    chk("arst m_data", {8'h0, m_data}, 0);
    chk("arst pulses", {29'h0, frame_end, err, overrun}, 0);
`ifdef RZ_DECODER_ERR_CNT_EN
    chk("arst err_cnt", err_cnt, 0);
`endif
    q.delete();
    @(negedge clk);
    rst_n = 1;
    m_ready = 1;
    snap();
    send_word(24'hABCDEF, 24, 31, 91, 0);
    repeat (5) @(negedge clk);
    chk("post-rst ignored words", words_n - s_w, 0);
    chk("post-rst ignored err", err_n - s_e, 0);
    idle(5010);
    q.push_back(24'h13579B);
    send_word(24'h13579B, 24, 31, 91, 0);
    repeat (5) @(negedge clk);
    chk("post-rst words", words_n - s_w, 1);
`ifdef RZ_DECODER_ERR_CNT_EN
    chk("cnt start", err_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      bad_pulse(55);
      idle(5010);
    end
    m_ready = 0;
    q.push_back(24'h246824);
    send_word(24'h246824, 24, 31, 91, 0);
    send_word(24'h975310, 24, 31, 91, 0);
    repeat (5) @(negedge clk);
    chk("err_cnt", err_cnt, 4);
    m_ready = 1;
    repeat (3) @(negedge clk);
`endif
    chk("scoreboard empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
